// File: rtl/irq_ack_dispatcher.sv
// irq_ack_dispatcher: req edges -> pend latches, winner code -> one-hot ack, four-phase handshake with timeout/err/svc_cnt
module irq_ack_dispatcher #(
  parameter int NCH     = 9,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   req_a,
  input  logic [NCH-1:0]   req_b,
  input  logic [NCH-1:0]   req_c,
  output logic [NCH-1:0]   pend_a,
  output logic [NCH-1:0]   pend_b,
  output logic [NCH-1:0]   pend_c,
  input  logic             win_valid,
  input  logic [1:0]       win_bus,
  input  logic [3:0]       win_chan,
  output logic [NCH-1:0]   ack_a,
  output logic [NCH-1:0]   ack_b,
  output logic [NCH-1:0]   ack_c,
  output logic             busy,
  output logic             err,
  output logic             tmo,
  output logic [CNT_W-1:0] svc_cnt
);
  localparam int N  = 3 * NCH;
  localparam int IW = $clog2(N);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [3:0] CMAX = 4'(NCH - 1);
  typedef enum logic [1:0] {IDLE, ACK, WAIT_REL, RECOVER} state_t;
  state_t           state_q, state_d;
  logic [N-1:0]     req_all, req_q, req_d, pend_q, pend_d, win_oh, sel_oh;
  logic [IW-1:0]    sel_q, sel_d, win_idx;
  logic [TW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] svc_q, svc_d;
  logic             err_q, err_d, tmo_q, tmo_d, code_ok, win_take, rel;
  assign req_all  = {req_c, req_b, req_a};
  assign win_idx  = IW'(win_bus) * IW'(NCH) + IW'(win_chan);
  assign code_ok  = (win_bus <= 2'd2) && (win_chan <= CMAX);
  assign win_oh   = N'(1) << win_idx;
  assign win_take = (state_q == IDLE) && win_valid && code_ok && |(pend_q & win_oh);
  assign sel_oh   = N'(1) << sel_q;
  assign rel      = ~|(req_all & sel_oh);
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    svc_d   = svc_q;
    tmo_d   = 1'b0;
    req_d   = req_all;
    err_d   = err_q | ((state_q == IDLE) && win_valid && !win_take);
    pend_d  = (pend_q & ~(win_take ? win_oh : '0)) | (req_all & ~req_q);
    case (state_q)
      IDLE: begin
        state_d = win_take ? ACK : IDLE;
        sel_d   = win_take ? win_idx : sel_q;
      end
      ACK: begin
        state_d = WAIT_REL;
        cnt_d   = '0;
      end
      WAIT_REL: begin
        if (rel) begin
          state_d = RECOVER;
          svc_d   = &svc_q ? svc_q : svc_q + 1'b1;
        end else if (cnt_q == TW'(TIMEOUT - 1)) begin
          state_d = RECOVER;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      svc_q   <= '0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
      req_q   <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      svc_q   <= svc_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
      req_q   <= req_d;
      pend_q  <= pend_d;
    end
  end
  assign {pend_c, pend_b, pend_a} = pend_q;
  assign {ack_c, ack_b, ack_a}    = (state_q == ACK || state_q == WAIT_REL) ? sel_oh : '0;
  assign busy    = state_q != IDLE;
  assign err     = err_q;
  assign tmo     = tmo_q;
  assign svc_cnt = svc_q;
endmodule

// File: tb/tb_irq_ack_dispatcher.sv
// tb_irq_ack_dispatcher: vector table, directed corner sequences and random traffic against a handshake model
module tb_irq_ack_dispatcher;
  localparam int NCH = 9;
  localparam int TMO = 8;
  localparam int CW  = 4;
  localparam int MAXC = (1 << CW) - 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [26:0] req_v = '0;
  logic win_valid = 1'b0;
  logic [1:0] win_bus = '0;
  logic [3:0] win_chan = '0;
  logic [8:0] pend_a, pend_b, pend_c, ack_a, ack_b, ack_c;
  logic busy, err, tmo;
  logic [CW-1:0] svc_cnt;
  int n_vec = 0;
  int n_bad = 0;
  logic [26:0] m_pend = '0, m_reqh = '0;
  int m_owner = -1, m_held = 0, m_cnt = 0;
  logic m_cool = 1'b0, m_err = 1'b0, m_tmo = 1'b0;
  typedef struct {
    logic rst;
    logic [26:0] req;
    logic wv;
    logic [1:0] bus;
    logic [3:0] chan;
    logic [26:0] ep, ea;
    logic eb, ee, et;
    logic [3:0] ec;
  } vec_t;
  vec_t tbl[14];
  irq_ack_dispatcher #(.NCH(NCH), .TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_v[8:0]), .req_b(req_v[17:9]), .req_c(req_v[26:18]),
    .pend_a(pend_a), .pend_b(pend_b), .pend_c(pend_c),
    .win_valid(win_valid), .win_bus(win_bus), .win_chan(win_chan),
    .ack_a(ack_a), .ack_b(ack_b), .ack_c(ack_c),
    .busy(busy), .err(err), .tmo(tmo), .svc_cnt(svc_cnt)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(logic r, logic [26:0] q, logic v, logic [1:0] b, logic [3:0] c,
                              logic [26:0] p, logic [26:0] a, logic bz, logic er, logic t, logic [3:0] n);
    vec_t x;
    x.rst = r; x.req = q; x.wv = v; x.bus = b; x.chan = c;
    x.ep = p; x.ea = a; x.eb = bz; x.ee = er; x.et = t; x.ec = n;
    return x;
  endfunction
  function automatic logic [63:0] dut_out();
    return {3'b0, pend_c, pend_b, pend_a, ack_c, ack_b, ack_a, busy, err, tmo, svc_cnt};
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic step();
    logic [26:0] rise, clr, eack;
    int idx;
    rise = req_v & ~m_reqh;
    clr = '0;
    m_tmo = 1'b0;
    if (rst) begin
      m_pend = '0; m_reqh = '0; m_owner = -1; m_held = 0; m_cool = 1'b0; m_err = 1'b0; m_cnt = 0;
    end else begin
      if (m_cool) m_cool = 1'b0;
      else if (m_owner >= 0) begin
        if (m_held >= 2 && !req_v[m_owner]) begin
          m_cnt = (m_cnt == MAXC) ? MAXC : m_cnt + 1;
          m_owner = -1; m_cool = 1'b1;
        end else if (m_held == TMO + 1) begin
          m_tmo = 1'b1; m_owner = -1; m_cool = 1'b1;
        end else m_held++;
      end else if (win_valid) begin
        idx = int'(win_bus) * NCH + int'(win_chan);
        if (win_bus <= 2 && win_chan < NCH && m_pend[idx]) begin
          m_owner = idx; m_held = 1; clr[idx] = 1'b1;
        end else m_err = 1'b1;
      end
      m_pend = (m_pend & ~clr) | rise;
      m_reqh = req_v;
    end
    eack = (m_owner >= 0) ? (27'd1 << m_owner) : 27'd0;
    @(posedge clk);
    #1;
    chk("model", dut_out(), {3'b0, m_pend, eack, (m_owner >= 0) || m_cool, m_err, m_tmo, CW'(m_cnt)});
  endtask
  task automatic idle_in();
    rst = 1'b0; win_valid = 1'b0; win_bus = '0; win_chan = '0;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
  initial begin
    int n, pulses, tries;
    int pick;
    tbl[0]  = mk(1, 27'h0,   0, 0, 0, 27'h0,   27'h0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 27'h8,   0, 0, 0, 27'h8,   27'h0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 27'h8,   1, 0, 3, 27'h0,   27'h8, 1, 0, 0, 0);
    tbl[3]  = mk(0, 27'h8,   0, 0, 0, 27'h0,   27'h8, 1, 0, 0, 0);
    tbl[4]  = mk(0, 27'h8,   0, 0, 0, 27'h0,   27'h8, 1, 0, 0, 0);
    tbl[5]  = mk(0, 27'h8,   0, 0, 0, 27'h0,   27'h8, 1, 0, 0, 0);
    tbl[6]  = mk(0, 27'h8,   0, 0, 0, 27'h0,   27'h8, 1, 0, 0, 0);
    tbl[7]  = mk(0, 27'h0,   0, 0, 0, 27'h0,   27'h0, 1, 0, 0, 1);
    tbl[8]  = mk(0, 27'h0,   0, 0, 0, 27'h0,   27'h0, 0, 0, 0, 1);
    tbl[9]  = mk(0, 27'h0,   1, 3, 0, 27'h0,   27'h0, 0, 1, 0, 1);
    tbl[10] = mk(1, 27'h0,   0, 0, 0, 27'h0,   27'h0, 0, 0, 0, 0);
    tbl[11] = mk(0, 27'h200, 1, 1, 9, 27'h200, 27'h0, 0, 1, 0, 0);
    tbl[12] = mk(1, 27'h0,   0, 0, 0, 27'h0,   27'h0, 0, 0, 0, 0);
    tbl[13] = mk(0, 27'h0,   1, 0, 2, 27'h0,   27'h0, 0, 1, 0, 0);
    for (int i = 0; i < 14; i++) begin
      rst = tbl[i].rst; req_v = tbl[i].req; win_valid = tbl[i].wv;
      win_bus = tbl[i].bus; win_chan = tbl[i].chan;
      step();
      chk($sformatf("vec%0d", i), dut_out(),
          {3'b0, tbl[i].ep, tbl[i].ea, tbl[i].eb, tbl[i].ee, tbl[i].et, tbl[i].ec});
    end
    // timeout: req_c[8] never released
    rst = 1'b1; req_v = '0; step();
    idle_in(); req_v = 27'd1 << 26; step();
    win_valid = 1'b1; win_bus = 2'd2; win_chan = 4'd8; step();
    idle_in();
    n = 0; pulses = 0;
    for (int i = 0; i < 4 * TMO; i++) begin
      step();
      pulses += int'(tmo);
      if (!ack_c[8]) break;
      n++;
    end
    chk("tmo_wait_cycles", 64'(n), 64'(TMO));
    for (int i = 0; i < 3; i++) begin
      step();
      pulses += int'(tmo);
    end
    chk("tmo_pulses", 64'(pulses), 64'd1);
    chk("tmo_svc", 64'(svc_cnt), 64'd0);
    req_v = '0; step();
    // reset during WAIT_REL with ack_b[5] high
    req_v = 27'd1 << 14; step();
    win_valid = 1'b1; win_bus = 2'd1; win_chan = 4'd5; step();
    idle_in(); step(); step();
    chk("ackb5_high", 64'(ack_b), 64'h20);
    rst = 1'b1; step();
    chk("rst_mid", dut_out(), 64'd0);
    // saturation of svc_cnt
    idle_in(); req_v = '0; step();
    for (int k = 0; k < MAXC + 5; k++) begin
      req_v = 27'd1; step();
      win_valid = 1'b1; win_bus = 2'd0; win_chan = 4'd0; step();
      idle_in(); step();
      req_v = '0; step();
      step();
    end
    chk("svc_sat", 64'(svc_cnt), 64'(MAXC));
    // same-edge set and clear of pend_a[1]
    rst = 1'b1; step();
    idle_in(); req_v = 27'h2; step();
    req_v = '0; step();
    req_v = 27'h2; win_valid = 1'b1; win_bus = 2'd0; win_chan = 4'd1; step();
    chk("same_edge_pend", {55'd0, pend_a}, 64'h2);
    chk("same_edge_ack", {55'd0, ack_a}, 64'h2);
    idle_in(); step();
    req_v = '0; step(); step();
    // randomized traffic
    rst = 1'b1; step();
    idle_in();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int b = 0; b < 27; b++)
        if ($urandom_range(0, 11) == 0) req_v[b] = ~req_v[b];
      win_valid = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0 && m_pend != 0) begin
        pick = $urandom_range(0, 26);
        tries = 0;
        while (!m_pend[pick] && tries < 200) begin
          pick = $urandom_range(0, 26);
          tries++;
        end
        win_bus = 2'(pick / NCH);
        win_chan = 4'(pick % NCH);
      end else begin
        win_bus = 2'($urandom_range(0, 3));
        win_chan = 4'($urandom_range(0, 15));
      end
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/irq_ack_dispatcher.md
Name: irq_ack_dispatcher

Overview:
Sequential front/back end for the 27-channel combinational priority interrupt controller (three 9-channel buses A/B/C, A highest). It captures request edges into pending latches that feed the controller, takes the controller's encoded winner (bus + channel), and decodes it into a one-hot acknowledge. A four-phase handshake with the requester follows, with timeout and error reporting.

Parameters:
NCH, 9, channels per bus (fixed at 9 to match the controller)
TIMEOUT, 64, max cycles ack is held waiting for requester release (>=2)
CNT_W, 16, width of serviced-interrupt counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
req_a  in  NCH  level requests, bus A (bit i = channel i)
req_b  in  NCH  level requests, bus B
req_c  in  NCH  level requests, bus C
pend_a  out  NCH  pending latches to controller, bus A
pend_b  out  NCH  pending latches, bus B
pend_c  out  NCH  pending latches, bus C
win_valid  in  1  controller reports a winner this cycle
win_bus  in  2  winner bus: 0=A, 1=B, 2=C, 3 illegal
win_chan  in  4  winner channel 0..8; 9..15 illegal
ack_a  out  NCH  one-hot acknowledge, bus A
ack_b  out  NCH  one-hot acknowledge, bus B
ack_c  out  NCH  one-hot acknowledge, bus C
busy  out  1  FSM not in IDLE
err  out  1  sticky: illegal or non-pending winner code
tmo  out  1  one-cycle pulse on handshake timeout
svc_cnt  out  CNT_W  completed handshakes, saturating

Behaviour:
- Reset (synchronous, rst high at edge): all pend/ack = 0, req history = 0, FSM = IDLE, busy = 0, err = 0, tmo = 0, svc_cnt = 0, timeout counter = 0. rst overrides everything, including mid-handshake; ack drops on the first edge with rst high.
- Edge capture: req_x_q registered each cycle. pend[i] set when req[i] & ~req_q[i]. pend[i] cleared on the ACK-entry edge for the selected bit. Same-edge set and clear of one bit: set wins.
- FSM states: IDLE, ACK, WAIT_REL, RECOVER.
- IDLE: win_valid sampled high at edge k:
  - Legal code (bus<=2, chan<=8, and the addressed pend bit = 1): latch sel = {bus, chan}, clear that pend bit, go to ACK. The ack bit is high in the cycle after edge k, giving 1-cycle latency.
  - Otherwise: set err, stay in IDLE, change no pend bit.
  - win_valid low: stay in IDLE.
- ACK: ack one-hot at sel; timeout counter = 0; next edge goes to WAIT_REL.
- WAIT_REL: ack held. Addressed req sampled low: drop ack, increment svc_cnt (saturating at all-ones), go to RECOVER. Else counter +1; on reaching TIMEOUT-1: drop ack, pulse tmo for 1 cycle, go to RECOVER, no svc_cnt increment.
- RECOVER: ack = 0 for exactly one cycle, then IDLE. win_valid is ignored in ACK/WAIT_REL/RECOVER.
- busy = (state != IDLE). At most one ack bit high across all 27 at any time.
- err clears only on rst.
- Requester re-raising req during RECOVER is a new edge and re-pends.

Test Plan:
- rst, then req_a[3] 0->1 -> pend_a=9'h008 next cycle; win_valid=1, bus=0, chan=3 -> ack_a=9'h008 one cycle later, pend_a=0, busy=1.
- Continue: drop req_a[3] 5 cycles after ack -> ack_a=0 next edge, svc_cnt=1, one RECOVER cycle, then busy=0.
- req_c[8] raised and held, winner bus=2/chan=8 -> ack_c[8] high exactly TIMEOUT cycles into WAIT_REL, then low, tmo pulses once, svc_cnt unchanged.
- win_valid with bus=3, then with bus=1/chan=9, then bus=0/chan=2 with pend_a[2]=0 -> err=1 after the first, FSM stays IDLE, pend unchanged, no ack.
- rst asserted during WAIT_REL with ack_b[5] high -> all outputs 0 after that edge; err and svc_cnt are 0.
- svc_cnt preloaded near max via 2^CNT_W completions (CNT_W=4 build) -> holds at 4'hF; same-edge rising req on the bit being cleared -> pend bit remains 1.
